inst_fetch: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the memory controller's instruction port (IF_op/IF_len/IF_addr out, IF_rdy/IF_out in).
- Owns the PC and issues sequential word fetches.
- Buffers returned instructions in a small FIFO toward decode (ID).
- Handles branch redirects: PC reload, queue flush, and discard of stale responses still in flight from the controller.

---
 rtl/inst_fetch_pkg.sv | 28 ++
 rtl/inst_fetch_if.sv | 29 ++
 rtl/inst_queue.sv | 65 ++++++
 rtl/inst_fetch.sv | 127 ++++++++++++
 tb/tb_inst_fetch.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and the memory controller port.
// Contents: memory op/length encodings, a zero word, fetch FSM states and the FIFO entry type.
package inst_fetch_pkg;

  // Memory operation encodings (IF_op)
  localparam logic [1:0] MEM_NOP  = 2'b00;
  localparam logic [1:0] MEM_LOAD = 2'b01;
  localparam logic [1:0] MEM_SAVE = 2'b10;

  // Access length encodings (IF_len)
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StFull   = 2'd1,
    StSquash = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction port between the fetch stage (master) and the memory controller (slave).
//   IF_op   : MEM_LOAD while requesting, MEM_NOP otherwise
//   IF_len  : access length, always MEM_WORD for fetches
//   IF_addr : fetch address
//   IF_rdy  : one-cycle pulse, IF_out valid for the last sampled IF_addr
//   IF_out  : returned instruction word
interface inst_fetch_if;
  logic [1:0]  IF_op;
  logic [1:0]  IF_len;
  logic [31:0] IF_addr;
  logic        IF_rdy;
  logic [31:0] IF_out;

  modport master (
    output IF_op,
    output IF_len,
    output IF_addr,
    input  IF_rdy,
    input  IF_out
  );

  modport slave (
    input  IF_op,
    input  IF_len,
    input  IF_addr,
    output IF_rdy,
    output IF_out
  );
endinterface

// File: rtl/inst_queue.sv
// Synchronous FIFO of {pc, inst} entries between fetch and decode.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data (accepted when not full, or full with a pop)
//   pop       : drop the head (ignored when empty)
//   flush     : empty the queue; wins over push and pop
//   full/empty/count : occupancy, count is clog2(DEPTH)+1 bits
//   head      : current head entry, all-zero when empty
module inst_queue
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == DepthCnt);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // Push into a full queue is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head = empty ? fetch_entry_t'({ZeroWord, ZeroWord}) : mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues sequential word fetches, queues the returned
// instructions toward decode and handles branch redirects.
//   clk_in, rst_in : clock, synchronous active-high reset
//   rdy_in         : global enable, all state frozen while low
//   jmp_in, jmp_target : redirect request and new PC
//   mem            : instruction port to the memory controller (master side)
//   id_valid/id_inst/id_pc/id_ready : queue head toward decode, popped on valid && ready
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned SQUASH_CYC  = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               jmp_in,
  input  logic [31:0]        jmp_target,
  inst_fetch_if.master       mem,
  output logic               id_valid,
  output logic [31:0]        id_inst,
  output logic [31:0]        id_pc,
  input  logic               id_ready
);

  localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned SqW  = (SQUASH_CYC == 0) ? 1 : $clog2(SQUASH_CYC + 1);
  localparam logic [SqW-1:0]  SqInit   = SqW'(SQUASH_CYC);
  localparam logic [CntW-1:0] DepthCnt = CntW'(QUEUE_DEPTH);

  fetch_state_e  state_q;
  logic [31:0]   pc_q;
  logic [SqW-1:0] sq_cnt_q;
  logic [1:0]    if_op_q;

  logic            q_push;
  logic            q_pop;
  logic            q_flush;
  logic            q_full;
  logic            q_empty;
  logic [CntW-1:0] q_count;
  fetch_entry_t    q_head;

  // A redirect overrides any push or pop in the same cycle.
  assign q_flush = rdy_in && jmp_in;
  assign q_pop   = rdy_in && !jmp_in && id_ready && !q_empty;
  assign q_push  = rdy_in && !jmp_in && (state_q == StRun) && mem.IF_rdy && (!q_full || q_pop);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      sq_cnt_q <= '0;
      if_op_q  <= MEM_LOAD;
    end else if (rdy_in) begin
      if (jmp_in) begin
        pc_q    <= jmp_target;
        if_op_q <= MEM_LOAD;
        if (SQUASH_CYC == 0) begin
          state_q <= StRun;
        end else begin
          state_q  <= StSquash;
          sq_cnt_q <= SqInit;
        end
      end else begin
        unique case (state_q)
          StRun: begin
            if (mem.IF_rdy) begin
              if (!q_full || q_pop) begin
                pc_q <= pc_q + 32'd4;
              end else begin
                // Response dropped; the same pc is refetched after the queue drains.
                state_q <= StFull;
                if_op_q <= MEM_NOP;
              end
            end
          end
          StFull: begin
            // Registered count only, so id_ready never reaches IF_op combinationally.
            if (q_count < DepthCnt) begin
              state_q <= StRun;
              if_op_q <= MEM_LOAD;
            end
          end
          StSquash: begin
            // Responses still in flight for the old path arrive during these cycles.
            if (sq_cnt_q <= SqW'(1)) begin
              sq_cnt_q <= '0;
              state_q  <= StRun;
            end else begin
              sq_cnt_q <= sq_cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= StRun;
            if_op_q <= MEM_LOAD;
          end
        endcase
      end
    end
  end

  inst_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (q_push),
    .push_data ({pc_q, mem.IF_out}),
    .pop       (q_pop),
    .flush     (q_flush),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head      (q_head)
  );

  assign mem.IF_op   = if_op_q;
  assign mem.IF_len  = MEM_WORD;
  assign mem.IF_addr = pc_q;

  assign id_valid = !q_empty;
  assign id_inst  = q_head.inst;
  assign id_pc    = q_head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by random stimulus, every
// cycle compared against a queue-based reference model of the fetch stage.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned SqCyc = 2;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        jmp;
  logic [31:0] tgt;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  inst_fetch_if mem_if ();

  inst_fetch #(
    .RESET_PC    (32'h0),
    .QUEUE_DEPTH (Depth),
    .SQUASH_CYC  (SqCyc)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .rdy_in     (rdy),
    .jmp_in     (jmp),
    .jmp_target (tgt),
    .mem        (mem_if),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_ready   (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pc, queue of {pc, inst}, mode (0 run, 1 full, 2 squash), squash cycles left.
  logic [31:0] m_pc = 32'h0;
  logic [63:0] m_q[$];
  int          m_mode = 0;
  int          m_sq = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  cnt;
    bit  pop;
    cnt = m_q.size();
    if (rst) begin
      m_pc = 32'h0;
      m_q.delete();
      m_mode = 0;
      m_sq = 0;
      return;
    end
    if (!rdy) return;
    if (jmp) begin
      m_q.delete();
      m_pc = tgt;
      m_mode = 2;
      m_sq = SqCyc;
      return;
    end
    pop = (cnt > 0) && id_ready;
    if (pop) void'(m_q.pop_front());
    case (m_mode)
      0: begin
        if (mem_if.IF_rdy) begin
          if (cnt < Depth || pop) begin
            m_q.push_back({m_pc, mem_if.IF_out});
            m_pc = m_pc + 32'd4;
          end else begin
            m_mode = 1;
          end
        end
      end
      1: if (cnt < Depth) m_mode = 0;
      default: begin
        m_sq--;
        if (m_sq == 0) m_mode = 0;
      end
    endcase
  endtask

  task automatic step();
    logic [63:0] head;
    model_step();
    @(posedge clk);
    #1;
    head = (m_q.size() != 0) ? m_q[0] : 64'h0;
    check_eq("IF_op", 32'(mem_if.IF_op), (m_mode == 1) ? 32'(MEM_NOP) : 32'(MEM_LOAD));
    check_eq("IF_len", 32'(mem_if.IF_len), 32'(MEM_WORD));
    check_eq("IF_addr", mem_if.IF_addr, m_pc);
    check_eq("id_valid", 32'(id_valid), 32'(m_q.size() != 0));
    check_eq("id_pc", id_pc, head[63:32]);
    check_eq("id_inst", id_inst, head[31:0]);
  endtask

  task automatic drive(input bit r, input bit rd, input bit j, input logic [31:0] t,
                       input bit fr, input logic [31:0] fo, input bit ir);
    rst = r;
    rdy = rd;
    jmp = j;
    tgt = t;
    mem_if.IF_rdy = fr;
    mem_if.IF_out = fo;
    id_ready = ir;
  endtask

  task automatic do_reset();
    drive(1, 1, 0, 32'h0, 0, 32'h0, 0);
    step();
  endtask

  initial begin
    drive(1, 1, 0, 32'h0, 0, 32'h0, 0);

    // Reset held two cycles, then idle: address stays at RESET_PC.
    step();
    step();
    check_eq("rst_addr", mem_if.IF_addr, 32'h0);
    check_eq("rst_op", 32'(mem_if.IF_op), 32'(MEM_LOAD));
    check_eq("rst_valid", 32'(id_valid), 32'h0);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
    step();
    step();
    check_eq("idle_addr", mem_if.IF_addr, 32'h0);

    // Sequential fetch with decode always ready.
    drive(0, 1, 0, 32'h0, 1, 32'h0000_0013, 1);
    step();
    check_eq("seq0_pc", id_pc, 32'h0);
    check_eq("seq0_inst", id_inst, 32'h0000_0013);
    drive(0, 1, 0, 32'h0, 1, 32'h0010_0093, 1);
    step();
    check_eq("seq1_pc", id_pc, 32'h4);
    check_eq("seq1_inst", id_inst, 32'h0010_0093);
    check_eq("seq_addr", mem_if.IF_addr, 32'h8);

    // Backpressure: fill the queue, fifth response is dropped.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 32'h0, 1, $urandom, 0);
      step();
    end
    drive(0, 1, 0, 32'h0, 1, 32'hDEAD_BEEF, 0);
    step();
    check_eq("bp_op", 32'(mem_if.IF_op), 32'(MEM_NOP));
    check_eq("bp_addr", mem_if.IF_addr, 32'd16);
    check_eq("bp_head", id_pc, 32'h0);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 1);
    step();
    drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
    step();
    check_eq("bp_run", 32'(mem_if.IF_op), 32'(MEM_LOAD));
    drive(0, 1, 0, 32'h0, 1, 32'h1234_5678, 0);
    step();
    check_eq("bp_addr2", mem_if.IF_addr, 32'd20);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 32'h0, 0, 32'h0, 1);
      step();
    end

    // Redirect with responses arriving during the squash window.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 32'h0, 1, $urandom, 0);
      step();
    end
    drive(0, 1, 1, 32'h1000, 1, $urandom, 1);
    step();
    check_eq("jmp_valid", 32'(id_valid), 32'h0);
    check_eq("jmp_addr", mem_if.IF_addr, 32'h1000);
    drive(0, 1, 0, 32'h0, 1, $urandom, 1);
    step();
    drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
    step();
    check_eq("sq_valid", 32'(id_valid), 32'h0);
    drive(0, 1, 0, 32'h0, 1, 32'h0000_000A, 0);
    step();
    check_eq("sq_pc", id_pc, 32'h1000);
    check_eq("sq_inst", id_inst, 32'h0000_000A);

    // Stall: nothing moves while rdy_in is low.
    drive(0, 1, 0, 32'h0, 1, $urandom, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 32'h0, i[0], $urandom, !i[0]);
      step();
    end
    check_eq("stall_addr", mem_if.IF_addr, 32'h1008);
    check_eq("stall_pc", id_pc, 32'h1000);

    // Full queue with push, pop and jump together, then push and pop without jump.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 32'h0, 1, $urandom, 0);
      step();
    end
    drive(0, 1, 1, 32'h2000, 1, $urandom, 1);
    step();
    check_eq("fj_valid", 32'(id_valid), 32'h0);
    check_eq("fj_addr", mem_if.IF_addr, 32'h2000);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 32'h0, 1, $urandom, 0);
      step();
    end
    drive(0, 1, 0, 32'h0, 1, $urandom, 1);
    step();
    check_eq("fpp_addr", mem_if.IF_addr, 32'h2014);
    check_eq("fpp_head", id_pc, 32'h2004);
    check_eq("fpp_op", 32'(mem_if.IF_op), 32'(MEM_LOAD));

    // Random traffic including unaligned targets and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 6, $urandom,
            $urandom_range(0, 1) == 1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
